// File: rtl/karatsuba16_mac_pkg.sv
// karatsuba16_mac_pkg: shared state enum and width constants for the karatsuba16 MAC
package karatsuba16_mac_pkg;
  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
  localparam int OPND_W = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W_DEF = 40;
  localparam logic [ACC_W_DEF-1:0] ACC_MAX = '1;
endpackage

// File: rtl/karatsuba16_mac_acc_add.sv
// mac_acc_add: accumulator adder with carry-out; saturates to all-ones when KARATSUBA16_MAC_SAT_EN is defined (acc, prod in; sum, carry out)
module mac_acc_add
  import karatsuba16_mac_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] raw;
  always_comb begin
    raw = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
    carry = raw[ACC_W];
`ifdef KARATSUBA16_MAC_SAT_EN
    // a saturated acc stays saturated: any nonzero add carries again
    sum = carry ? '1 : raw[ACC_W-1:0];
`else
    sum = raw[ACC_W-1:0];
`endif
  end
endmodule

// File: rtl/karatsuba16_mac_karatsuba16.sv
// karatsuba16: combinational unsigned 16x16->32 multiplier, one level of Karatsuba on 8-bit halves (x, y in; prod out)
module karatsuba16
  import karatsuba16_mac_pkg::*;
(
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  output logic [PROD_W-1:0] prod
);
  localparam int H = OPND_W / 2;
  logic [H-1:0] xh, xl, yh, yl;
  logic [2*H-1:0] z0, z2;
  logic [H:0] xs, ys;
  logic [2*H+1:0] zm, z1;
  always_comb begin
    xh = x[OPND_W-1:H];
    xl = x[H-1:0];
    yh = y[OPND_W-1:H];
    yl = y[H-1:0];
    z2 = {{H{1'b0}}, xh} * {{H{1'b0}}, yh};
    z0 = {{H{1'b0}}, xl} * {{H{1'b0}}, yl};
    xs = {1'b0, xh} + {1'b0, xl};
    ys = {1'b0, yh} + {1'b0, yl};
    zm = {{(H+1){1'b0}}, xs} * {{(H+1){1'b0}}, ys};
    // middle term xh*yl + xl*yh recovered from the cross product
    z1 = zm - {2'b00, z2} - {2'b00, z0};
    prod = {z2, z0} + {{(PROD_W-3*H-2){1'b0}}, z1, {H{1'b0}}};
  end
endmodule

// File: rtl/karatsuba16_mac.sv
// karatsuba16_mac: streaming 16x16 multiply-accumulate producing one dot product per burst.
//   in_valid/in_ready/in_x/in_y/in_last: operand stream, in_last ends a burst
//   out_valid/out_ready/out_acc/out_cnt/out_ovf: burst result, held until handoff
//   Macro KARATSUBA16_MAC_SAT_EN selects saturating instead of wrapping accumulation.
module karatsuba16_mac
  import karatsuba16_mac_pkg::*;
#(
  parameter int ACC_W = $bits(ACC_MAX),
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_x,
  input  logic [OPND_W-1:0] in_y,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);
  state_t state;
  logic [OPND_W-1:0] x1, y1;
  logic last1, v1, last2, v2;
  logic [PROD_W-1:0] prod, prod2;
  logic [ACC_W-1:0] acc, sum;
  logic carry;
  logic [CNT_W-1:0] cnt;
  logic ovf;
  logic accept;
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  assign accept = in_valid & in_ready;
  assign out_acc = acc;
  assign out_cnt = cnt;
  assign out_ovf = ovf;
  karatsuba16 u_mul (
    .x(x1),
    .y(y1),
    .prod(prod)
  );
  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc(acc),
    .prod(prod2),
    .sum(sum),
    .carry(carry)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      x1 <= '0;
      y1 <= '0;
      last1 <= 1'b0;
      v1 <= 1'b0;
      prod2 <= '0;
      last2 <= 1'b0;
      v2 <= 1'b0;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        x1 <= in_x;
        y1 <= in_y;
        last1 <= in_last;
      end
      v2 <= v1;
      if (v1) begin
        prod2 <= prod;
        last2 <= last1;
      end
      if (v2) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
        ovf <= ovf | carry;
      end
      if (state == ACCUM && accept && in_last) state <= DRAIN;
      if (state == DRAIN && v2 && last2) state <= HOLD;
      if (state == HOLD && out_ready) begin
        state <= ACCUM;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule
